// File: rtl/intc_pkg.sv
// Shared definitions for the intc_responder interrupt controller:
// register offsets, VECTOR layout and the register-window decode helper.
package intc_pkg;

  localparam logic [3:0] OFF_PENDING = 4'h0;
  localparam logic [3:0] OFF_MASK    = 4'h4;
  localparam logic [3:0] OFF_VECTOR  = 4'h8;
  localparam logic [3:0] OFF_EOI     = 4'hC;

  localparam int VECTOR_VALID_BIT = 31;
  localparam int MAX_NSRC         = 16;
  localparam int ID_W             = $clog2(MAX_NSRC);

  typedef enum logic [1:0] {
    REG_PENDING,
    REG_MASK,
    REG_VECTOR,
    REG_EOI
  } reg_e;

  // Maps the word index addr[3:2] to a register; byte lanes never matter.
  function automatic reg_e decode_reg(input logic [1:0] word);
    reg_e r;
    case ({word, 2'b00})
      OFF_MASK:   r = REG_MASK;
      OFF_VECTOR: r = REG_VECTOR;
      OFF_EOI:    r = REG_EOI;
      default:    r = REG_PENDING;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/intc_prio_enc.sv
// Lowest-index-first priority encoder: reports whether any request is set
// and the index of the lowest-numbered one.
module intc_prio_enc
  import intc_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]    req,
  output logic            valid,
  output logic [ID_W-1:0] id
);

  // Scanning downwards lets the lowest set index overwrite any higher one.
  always_comb begin
    valid = 1'b0;
    id    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        id    = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/intc_responder.sv
// Memory-mapped interrupt controller on the CPU data bus.
// Define INTC_SYNC_EN to put a 2-flop synchroniser on every source line.
module intc_responder
  import intc_pkg::*;
#(
  parameter int          NSRC      = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0100
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wren,
  input  logic [31:0]     addr,
  input  logic [31:0]     dataIn,
  output logic [31:0]     dataOut,
  input  logic [NSRC-1:0] src,
  output logic            intr
);

`ifdef INTC_SYNC_EN
  localparam int CHAIN = 3;
`else
  localparam int CHAIN = 1;
`endif

  logic            sel;
  logic            wr;
  reg_e            reg_id;
  logic [NSRC-1:0] s;
  logic [NSRC-1:0] s_q;
  logic [NSRC-1:0] det;
  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] mask;
  logic [NSRC-1:0] active;
  logic [NSRC-1:0] w1c_clr;
  logic [NSRC-1:0] eoi_clr;
  logic [CHAIN-1:0] primed;
  logic            vec_valid;
  logic [ID_W-1:0] vec_id;
  logic            unused_bits;

  assign sel    = (addr[31:4] == BASE_ADDR[31:4]);
  assign reg_id = decode_reg(addr[3:2]);
  assign wr     = wren & sel;

  assign unused_bits = ^{addr[1:0], dataIn};

`ifdef INTC_SYNC_EN
  logic [NSRC-1:0] sync1;
  logic [NSRC-1:0] sync2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= src;
      sync2 <= sync1;
    end
  end

  assign s = sync2;
`else
  assign s = src;
`endif

  // Edge detection stays blocked until every flop in the source path holds a
  // post-reset sample, so levels already high during reset are not seen as edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_q    <= '0;
      primed <= '0;
    end else begin
      s_q    <= s;
      primed <= (primed << 1) | CHAIN'(1);
    end
  end

  assign det = primed[CHAIN-1] ? (s & ~s_q) : '0;

  always_comb begin
    w1c_clr = '0;
    eoi_clr = '0;
    if (wr && reg_id == REG_PENDING) begin
      w1c_clr = dataIn[NSRC-1:0];
    end
    if (wr && reg_id == REG_EOI) begin
      for (int i = 0; i < NSRC; i++) begin
        eoi_clr[i] = (dataIn[3:0] == 4'(i));
      end
    end
  end

  // A new edge is OR-ed in after the clear so it survives a colliding clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~(w1c_clr | eoi_clr)) | det;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask <= '0;
    end else if (wr && reg_id == REG_MASK) begin
      mask <= dataIn[NSRC-1:0];
    end
  end

  assign active = pending & mask;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      intr <= 1'b0;
    end else begin
      intr <= |active;
    end
  end

  intc_prio_enc #(
    .N(NSRC)
  ) u_prio (
    .req  (active),
    .valid(vec_valid),
    .id   (vec_id)
  );

  always_comb begin
    dataOut = '0;
    if (sel) begin
      case (reg_id)
        REG_PENDING: dataOut = 32'(pending);
        REG_MASK:    dataOut = 32'(mask);
        REG_VECTOR: begin
          dataOut[VECTOR_VALID_BIT] = vec_valid;
          dataOut[ID_W-1:0]         = vec_id;
        end
        default:     dataOut = '0;
      endcase
    end
  end

endmodule

// File: doc/intc_responder.md
Name: intc_responder

Overview:
- Memory-mapped interrupt controller. Sits on the CPU data bus as a responder, alongside the data memory.
- Samples up to NSRC external interrupt sources and latches their rising edges into pending bits.
- Applies a mask and drives the CPU's single intr input.
- Software reads the highest-priority pending ID from a vector register and clears pending bits through W1C or EOI writes.

Parameters:
- NSRC, 8, number of interrupt sources (1..16).
- BASE_ADDR, 32'h0000_0100, byte base address of the 16-byte register window; must be 16-byte aligned.

Ports:
- clk  in  1  system clock (the CPU clock after the PLL).
- reset  in  1  asynchronous, active-low reset.
- wren  in  1  CPU data-bus write enable.
- addr  in  32  CPU data-bus byte address.
- dataIn  in  32  CPU write data.
- dataOut  out  32  read data to CPU; combinational.
- src  in  NSRC  raw interrupt source lines, active-high.
- intr  out  1  interrupt request to CPU; registered.

Behaviour:
- Reset: async assert when reset=0. Clears pending, mask, sync/edge flops and intr to 0. dataOut follows its combinational equation (0 unless selected).
- Select: sel = (addr[31:4] == BASE_ADDR[31:4]). addr[1:0] is ignored; only word access is supported.
- Register map (offset, access):
  - 0x0 PENDING (R; W1C on bits [NSRC-1:0]).
  - 0x4 MASK (R/W; 1 = enabled).
  - 0x8 VECTOR (R only): bit31 = valid, [3:0] = id. id is the lowest-numbered bit of pending&mask; lower index = higher priority. When no bit is enabled and pending, valid=0 and id=0.
  - 0xC EOI (W only): clears pending[dataIn[3:0]] if the index is < NSRC; otherwise no effect. Reads as 0.
- Reads: dataOut is combinational from addr, with zero latency, as required by the single-cycle datapath. Unimplemented bits read 0. dataOut = 0 when sel=0.
- Writes: take effect on the clk rising edge when wren=1 and sel=1. Writes to VECTOR are ignored.
- Edge detect: det[i] = s[i] & ~s_q[i], where s is the (optionally synchronised) source. Pending sets on det. Level-held sources do not re-set pending once cleared.
- Simultaneous set and clear: when det[i] coincides with a W1C or EOI clear of bit i in the same cycle, set wins and the bit stays 1.
- intr: registered as intr <= |(pending & mask), so it rises 1 cycle after pending becomes set (or after a MASK write). It falls the cycle after the last enabled pending bit clears.
- Masked sources: edges still latch into pending. Unmasking a pending source raises intr on the next edge.
- Width: mask and pending are NSRC bits. Unused upper bits of dataIn are ignored.
- Reset mid-operation: all state is cleared immediately. Edges occurring during reset are lost.

Optional Feature:
- Macro INTC_SYNC_EN.
- Defined: each src bit passes through a 2-flop synchroniser before edge detect, so edge-to-pending latency is 3 cycles and edge-to-intr is 4.
- Undefined: src is assumed synchronous to clk, so edge-to-pending latency is 1 cycle and edge-to-intr is 2.

Decomposition:
- Shared package intc_pkg holds:
  - register offset constants OFF_PENDING=4'h0, OFF_MASK=4'h4, OFF_VECTOR=4'h8, OFF_EOI=4'hC;
  - VECTOR_VALID_BIT=31;
  - MAX_NSRC=16.
- One sub-module, intc_prio_enc: parameterised lowest-index-first priority encoder producing {valid, id[3:0]}.

Test Plan (NSRC=8, BASE 0x100, INTC_SYNC_EN defined):
- Reset: hold reset=0 with src=8'hFF, then release → pending=0, mask=0, intr=0. Reading 0x100, 0x104 and 0x108 returns 0.
- Single edge: write MASK=0x04, then pulse src[2] → pending=0x04 after 3 cycles, intr=1 on cycle 4, VECTOR=0x8000_0002. Write EOI=2 → intr=0 on the next cycle.
- Priority: set edges on src[5] and src[1] with MASK=0xFF → VECTOR=0x8000_0001. Write W1C 0x02 to 0x100 → VECTOR=0x8000_0005.
- Masked latch: with MASK=0, an edge on src[7] gives pending=0x80 and intr=0. Write MASK=0x80 → intr=1 one cycle later.
- Set-wins collision: write W1C 0x08 in the same cycle that det[3] fires → pending[3] remains 1.
- Decode and bounds: a write to 0x110, or EOI=9, leaves all state unchanged; a read at 0x0FC returns 0.
